// File: rtl/ss_wb_pkg.sv
// Shared types and constants for the DMA-side Wishbone arbiter and its helpers.
package ss_wb_pkg;

    localparam int NCH_DEF = 5;
    localparam int CH_M    = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ss_rr_pick.sv
// Combinational round-robin selector: first set req bit scanning last+1, last+2, ... mod NCH.
// Zero latency; no backpressure, valid is low when no bit of req is set.
module ss_rr_pick #(
    parameter int NCH = 5
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] last,
    output logic [$clog2(NCH)-1:0] sel,
    output logic                   valid
);

    localparam int IW = $clog2(NCH);

    logic [IW-1:0] idx;

    // Walk from the farthest offset down so the nearest requester after last wins.
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NCH);
            if (req[idx]) begin
                sel   = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ss_wb_arbiter.sv
// Round-robin Wishbone arbiter for the DMA channels and channel M; grant held for a whole cycle.
// Latency: req at edge N gives gnt at edge N+1; one idle gap between owners.
// Backpressure: late requesters wait until IDLE; SS_ARB_WATCHDOG_EN adds a forced-release watchdog.
module ss_wb_arbiter
    import ss_wb_pkg::*;
#(
    parameter int NCH     = NCH_DEF,
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NCH-1:0]         req,
    input  logic                   wbm_ack_i,
    input  logic                   wbm_err_i,
    input  logic                   wbm_rty_i,
    output logic [NCH-1:0]         gnt,
    output logic [$clog2(NCH)-1:0] owner,
    output logic                   busy,
    output logic                   tmo
);

    localparam int IW = $clog2(NCH);
    localparam logic [NCH-1:0] GNT_ONE = NCH'(1);

    if (TMO_CYC < 1 || TMO_CYC >= (1 << TMO_W)) begin : g_bad_tmo
        $error("TMO_CYC must be in 1 .. 2**TMO_W-1");
    end

    arb_state_e     state_q, state_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  last_q, last_d;

    logic [IW-1:0]  pick_sel;
    logic           pick_vld;
    logic           rel_own, rel_rty, rel_wd;

    ss_rr_pick #(.NCH(NCH)) u_pick (
        .req   (req),
        .last  (last_q),
        .sel   (pick_sel),
        .valid (pick_vld)
    );

    assign rel_own = (req & gnt_q) == '0;
    assign rel_rty = wbm_rty_i;

`ifdef SS_ARB_WATCHDOG_EN
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             bus_resp;

    assign bus_resp = wbm_ack_i | wbm_err_i | wbm_rty_i;
    // Expiry fires on the BUSY cycle that would take the silent count up to TMO_CYC.
    assign rel_wd   = (state_q == ST_BUSY) && !bus_resp
                      && ((cnt_q + 1'b1) == TMO_W'(TMO_CYC));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        tmo_d = rel_wd && !rel_own && !rel_rty;
        if (state_q != ST_BUSY || bus_resp || rel_wd) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign tmo = tmo_q;
`else
    logic unused_resp;

    assign unused_resp = wbm_ack_i ^ wbm_err_i;
    assign rel_wd      = 1'b0;
    assign tmo         = 1'b0;
`endif

    // last only moves on a new grant, so a retry or timeout leaves it at the owner.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = GNT_ONE << pick_sel;
                    owner_d = pick_sel;
                    last_d  = pick_sel;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (rel_own || rel_rty || rel_wd) begin
                    gnt_d   = '0;
                    owner_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                owner_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= IW'(NCH - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = (state_q == ST_BUSY);

endmodule

// File: tb/tb_ss_wb_arbiter.sv
// Scenario bench for ss_wb_arbiter: expected outputs are queued per cycle and checked after each edge.
module tb_ss_wb_arbiter;

    typedef struct packed {
        logic [4:0] gnt;
        logic [2:0] owner;
        logic       busy;
        logic       tmo;
    } exp_t;

    localparam exp_t IDLE_E = '0;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic [4:0] req      = '0;
    logic       wbm_ack_i = 1'b0;
    logic       wbm_err_i = 1'b0;
    logic       wbm_rty_i = 1'b0;
    logic [4:0] gnt;
    logic [2:0] owner;
    logic       busy;
    logic       tmo;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    exp_t e;

    ss_wb_arbiter dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .req       (req),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .wbm_rty_i (wbm_rty_i),
        .gnt       (gnt),
        .owner     (owner),
        .busy      (busy),
        .tmo       (tmo)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic exp_t own(input int ch);
        exp_t r;
        r.gnt   = 5'b00001 << ch;
        r.owner = 3'(ch);
        r.busy  = 1'b1;
        r.tmo   = 1'b0;
        return r;
    endfunction

    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            total++;
            if (!$onehot0(gnt)) begin
                bad++;
                $display("FAIL onehot: gnt=%b is multi-hot", gnt);
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            wb_rst_i = (i < 2);
            req = 5'b11111;
            if (i == 2) req = '0;
            exp_q.push_back(IDLE_E);
            @(posedge wb_clk_i); #1;
            e = exp_q.pop_front(); total++;
            if ({gnt, owner, busy, tmo} !== e) begin
                bad++;
                $display("FAIL reset step %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b",
                         i, gnt, owner, busy, tmo, e.gnt, e.owner, e.busy, e.tmo);
            end
        end
    endtask

    task automatic test_rr_order();
        for (int k = 0; k < 6; k++) begin
            for (int s = 0; s < 4; s++) begin
                req       = (s == 3) ? (5'b11111 & ~(5'b00001 << (k % 5))) : 5'b11111;
                wbm_ack_i = (s == 1 || s == 2);
                exp_q.push_back((s == 3) ? IDLE_E : own(k % 5));
                @(posedge wb_clk_i); #1;
                e = exp_q.pop_front(); total++;
                if ({gnt, owner, busy, tmo} !== e) begin
                    bad++;
                    $display("FAIL rr_order turn %0d step %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b",
                             k, s, gnt, owner, busy, tmo, e.gnt, e.owner, e.busy, e.tmo);
                end
            end
        end
        wbm_ack_i = 1'b0;
    endtask

    task automatic test_single_hold();
        for (int i = 0; i < 13; i++) begin
            req       = (i < 11) ? 5'b00100 : 5'b00000;
            wbm_ack_i = (i >= 1 && i <= 10);
            exp_q.push_back((i < 11) ? own(2) : IDLE_E);
            @(posedge wb_clk_i); #1;
            e = exp_q.pop_front(); total++;
            if ({gnt, owner, busy, tmo} !== e) begin
                bad++;
                $display("FAIL single_hold step %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b",
                         i, gnt, owner, busy, tmo, e.gnt, e.owner, e.busy, e.tmo);
            end
        end
        wbm_ack_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [4:0] reqs [5] = '{5'b10011, 5'b11111, 5'b11111, 5'b11111, 5'b00000};
        for (int i = 0; i < 5; i++) begin
            req = reqs[i];
            exp_q.push_back((i < 4) ? own(4) : IDLE_E);
            @(posedge wb_clk_i); #1;
            e = exp_q.pop_front(); total++;
            if ({gnt, owner, busy, tmo} !== e) begin
                bad++;
                $display("FAIL simultaneous step %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b",
                         i, gnt, owner, busy, tmo, e.gnt, e.owner, e.busy, e.tmo);
            end
        end
    endtask

    task automatic test_retry();
        logic [4:0] reqs [8] = '{5'b00010, 5'b00011, 5'b00011, 5'b00000,
                                 5'b00010, 5'b00010, 5'b00010, 5'b00000};
        logic       rtys [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_t       exps [8];
        exps = '{own(1), IDLE_E, own(0), IDLE_E, own(1), IDLE_E, own(1), IDLE_E};
        for (int i = 0; i < 8; i++) begin
            req       = reqs[i];
            wbm_rty_i = rtys[i];
            exp_q.push_back(exps[i]);
            @(posedge wb_clk_i); #1;
            e = exp_q.pop_front(); total++;
            if ({gnt, owner, busy, tmo} !== e) begin
                bad++;
                $display("FAIL retry step %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b",
                         i, gnt, owner, busy, tmo, e.gnt, e.owner, e.busy, e.tmo);
            end
        end
        wbm_rty_i = 1'b0;
    endtask

    task automatic test_err_no_release();
        for (int i = 0; i < 6; i++) begin
            req       = (i < 4) ? 5'b01000 : 5'b00000;
            wbm_err_i = (i == 2 || i == 5);
            wbm_ack_i = (i == 5);
            wbm_rty_i = (i == 5);
            exp_q.push_back((i < 4) ? own(3) : IDLE_E);
            @(posedge wb_clk_i); #1;
            e = exp_q.pop_front(); total++;
            if ({gnt, owner, busy, tmo} !== e) begin
                bad++;
                $display("FAIL err_no_release step %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b",
                         i, gnt, owner, busy, tmo, e.gnt, e.owner, e.busy, e.tmo);
            end
        end
        wbm_err_i = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_rty_i = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        logic [4:0] reqs [5] = '{5'b10000, 5'b10000, 5'b11111, 5'b10001, 5'b00000};
        exp_t       exps [5];
        exps = '{own(4), own(4), IDLE_E, own(0), IDLE_E};
        for (int i = 0; i < 5; i++) begin
            req      = reqs[i];
            wb_rst_i = (i == 2);
            exp_q.push_back(exps[i]);
            @(posedge wb_clk_i); #1;
            e = exp_q.pop_front(); total++;
            if ({gnt, owner, busy, tmo} !== e) begin
                bad++;
                $display("FAIL reset_mid_grant step %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b",
                         i, gnt, owner, busy, tmo, e.gnt, e.owner, e.busy, e.tmo);
            end
        end
    endtask

`ifdef SS_ARB_WATCHDOG_EN
    task automatic test_watchdog(input int ack_at, input int lim);
        exp_t fired;
        fired = IDLE_E;
        fired.tmo = 1'b1;
        for (int i = 0; i <= lim + 1; i++) begin
            req       = (i <= lim) ? 5'b00001 : 5'b00000;
            wbm_ack_i = (i == ack_at);
            if (i < lim)       exp_q.push_back(own(0));
            else if (i == lim) exp_q.push_back(fired);
            else               exp_q.push_back(IDLE_E);
            @(posedge wb_clk_i); #1;
            e = exp_q.pop_front(); total++;
            if ({gnt, owner, busy, tmo} !== e) begin
                bad++;
                $display("FAIL watchdog step %0d: got %b/%0d/%b/%b want %b/%0d/%b/%b",
                         i, gnt, owner, busy, tmo, e.gnt, e.owner, e.busy, e.tmo);
            end
        end
        wbm_ack_i = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rr_order();
        test_single_hold();
        test_simultaneous();
        test_retry();
        test_err_no_release();
        test_reset_mid_grant();
`ifdef SS_ARB_WATCHDOG_EN
        test_watchdog(-1, 255);
        test_watchdog(200, 455);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
